alu_serial_seq: RTL and testbench

- Multi-cycle, bit-serial ALU sequencer.
- Accepts full-width operands and a 3-bit op over a valid/ready handshake.
- Drives one combinational 1-bit ALU slice LSB-to-MSB, one bit per clock, with the carry held in a flop. Resolves SLT by back-filling bit 0 after the MSB pass.
- Sits between the control unit and the register-file write-back path as the area-minimal ALU alternative.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_serial_seq_slice.sv | 34 +++
 rtl/alu_serial_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_serial_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings, FSM states
// and index-width helpers.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_ADD  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    SETFIX = 2'b10,
    DONE   = 2'b11
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_IDX_W = $clog2(DEF_WIDTH);

  // Bit-index width for a given operand width, never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_serial_seq_slice.sv
// One-bit combinational ALU slice: AND / OR / full-add / pass-through less.
// binvert complements b before every function so SUB/SLT reuse the adder.
module alu_bit_slice
  import alu_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binvert,
  input  logic [1:0] sel,
  input  logic       less,
  output logic       result,
  output logic       cout,
  output logic       sum
);

  logic b_eff;

  assign b_eff = b ^ binvert;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

  always_comb begin
    result = 1'b0;
    unique case (sel)
      SEL_AND:  result = a & b_eff;
      SEL_OR:   result = a | b_eff;
      SEL_ADD:  result = sum;
      SEL_LESS: result = less;
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks operands LSB-to-MSB through alu_bit_slice,
// back-filling bit 0 for SLT. Define ALU_SEQ_2BIT_EN to process two bits per cycle.
module alu_serial_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  localparam int IDX_W = idx_width(WIDTH);
`ifdef ALU_SEQ_2BIT_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             cout_q;
  logic             set_q;

  logic [WIDTH-1:0] result_d;
  logic             last_step;
  logic             carry_d;
  logic             carry_into_msb;
  logic             sum_msb;
  logic             ovf_fin;
  logic             set_fin;
  logic             is_arith;
  logic             is_add;
  logic             is_slt;

  logic s0_res;
  logic s0_cout;
  logic s0_sum;

  alu_bit_slice u_slice0 (
    .a       (a_q[idx_q]),
    .b       (b_q[idx_q]),
    .cin     (carry_q),
    .binvert (op_q[2]),
    .sel     (op_q[1:0]),
    .less    (1'b0),
    .result  (s0_res),
    .cout    (s0_cout),
    .sum     (s0_sum)
  );

`ifdef ALU_SEQ_2BIT_EN
  logic             s1_res;
  logic             s1_cout;
  logic             s1_sum;
  logic [IDX_W-1:0] idx_hi;

  // idx_q is always even here, so the upper bit is idx_q + 1.
  assign idx_hi = idx_q | IDX_W'(1);

  alu_bit_slice u_slice1 (
    .a       (a_q[idx_hi]),
    .b       (b_q[idx_hi]),
    .cin     (s0_cout),
    .binvert (op_q[2]),
    .sel     (op_q[1:0]),
    .less    (1'b0),
    .result  (s1_res),
    .cout    (s1_cout),
    .sum     (s1_sum)
  );

  assign last_step      = (idx_q == IDX_W'(WIDTH - 2));
  assign carry_d        = s1_cout;
  assign carry_into_msb = s0_cout;
  assign sum_msb        = s1_sum;

  logic unused_s0_sum;
  assign unused_s0_sum = s0_sum;

  always_comb begin
    result_d = result_q;
    result_d[idx_q +: 2] = {s1_res, s0_res};
  end
`else
  assign last_step      = (idx_q == IDX_W'(WIDTH - 1));
  assign carry_d        = s0_cout;
  assign carry_into_msb = carry_q;
  assign sum_msb        = s0_sum;

  always_comb begin
    result_d = result_q;
    result_d[idx_q] = s0_res;
  end
`endif

  assign ovf_fin  = carry_into_msb ^ carry_d;
  // Sign of the difference corrected for overflow gives the true signed compare.
  assign set_fin  = sum_msb ^ ovf_fin;
  assign is_arith = op_q[1];
  assign is_add   = (op_q[1:0] == SEL_ADD);
  assign is_slt   = (op_q[1:0] == SEL_LESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      set_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            carry_q  <= op[2];
            idx_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            set_q    <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          idx_q    <= idx_q + IDX_W'(STEP);
          if (last_step) begin
            cout_q <= is_arith & carry_d;
            ovf_q  <= is_add & ovf_fin;
            set_q  <= set_fin;
            if (is_slt) begin
              state_q <= SETFIX;
            end else begin
              zero_q  <= ~|result_d;
              state_q <= DONE;
            end
          end
        end
        SETFIX: begin
          result_q <= {{(WIDTH-1){1'b0}}, set_q};
          ovf_q    <= 1'b0;
          zero_q   <= ~set_q;
          state_q  <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            zero_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE) & ~rst;
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq (WIDTH=32); driver pushes expectations,
// a negedge monitor pops and compares whenever res_valid rises.
module tb_alu_serial_seq;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_2BIT_EN
  localparam int RUN_LAT = 16;
`else
  localparam int RUN_LAT = 32;
`endif

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        cout;
    int          lat;
    int          acc;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        cout;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t sb[$];

  alu_serial_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .cout        (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int tag, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (vec%0d): got 0x%08h expected 0x%08h", nm, tag, act, exp);
    end
  endfunction

  // Monitor: one pop per result presentation, then hold checks while stalled.
  logic        seen = 1'b0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else if (res_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = result;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got 0x%08h expected no result", result);
        end else begin
          e = sb.pop_front();
          chk("result",   e.tag, result,          e.res);
          chk("zero",     e.tag, {31'b0, zero},     {31'b0, e.zero});
          chk("overflow", e.tag, {31'b0, overflow}, {31'b0, e.ovf});
          chk("cout",     e.tag, {31'b0, cout},     {31'b0, e.cout});
          chk("latency",  e.tag, cyc - e.acc,       e.lat);
        end
      end else begin
        chk("hold_result",      -1, result,               held);
        chk("hold_start_ready", -1, {31'b0, start_ready}, 32'd0);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic issue(input int tag, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er, input logic ez,
                       input logic eo, input logic ec, input bit push);
    exp_t e;
    int   n;
    @(negedge clk);
    start_valid = 1'b1;
    a  = av;
    b  = bv;
    op = o;
    n  = 0;
    while (!start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout (vec%0d): got start_ready=0 expected 1", tag);
      start_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    if (push) begin
      e.res  = er;
      e.zero = ez;
      e.ovf  = eo;
      e.cout = ec;
      e.lat  = (o[1:0] == 2'b11) ? RUN_LAT + 1 : RUN_LAT;
      e.acc  = cyc;
      e.tag  = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL result_timeout (vec%0d): got %0d pending expected 0", tag, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_result",      0, result,               32'd0);
    chk("rst_res_valid",   0, {31'b0, res_valid},   32'd0);
    chk("rst_start_ready", 0, {31'b0, start_ready}, 32'd0);
    chk("rst_flags",       0, {29'b0, zero, overflow, cout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_start_ready", 0, {31'b0, start_ready}, 32'd1);

    issue(1, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done(1);
    issue(2, OP_SUB, 32'd5, 32'd5, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(2);
    issue(3, OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(3);
    issue(4, OP_SLT, 32'hFFFFFFFF, 32'd1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(4);
    issue(5, OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done(5);
    issue(6, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(6);
    issue(7, OP_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(7);
    issue(8, OP_ADD, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(8);
    // Illegal code 100: AND with b inverted, no carry reported.
    issue(9, 3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(9);

    // Backpressure: result must hold and no new request may be taken.
    res_ready = 1'b0;
    issue(10, OP_OR, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(10);
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      a  = 32'd100;
      b  = 32'd200;
      op = OP_ADD;
      @(negedge clk);
      chk("bp_res_valid",   10, {31'b0, res_valid},   32'd1);
      chk("bp_start_ready", 10, {31'b0, start_ready}, 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    chk("release_res_valid",   10, {31'b0, res_valid},   32'd0);
    chk("release_start_ready", 10, {31'b0, start_ready}, 32'd1);
    issue(11, OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(11);

    // Reset in the middle of RUN: partial result is dropped.
    issue(12, OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    chk("midrun_result_nonzero", 12, {31'b0, (result != 32'd0)}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_result",      12, result,               32'd0);
    chk("midrst_res_valid",   12, {31'b0, res_valid},   32'd0);
    chk("midrst_start_ready", 12, {31'b0, start_ready}, 32'd0);
    chk("midrst_flags",       12, {29'b0, zero, overflow, cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_start_ready", 12, {31'b0, start_ready}, 32'd1);
    issue(13, OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(13);

    repeat (5) @(negedge clk);
    chk("no_stray_results", 0, sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
